// File: rtl/var_bw_div_pkg.sv
// var_bw_div_pkg: shared types and sizing for the variable bit-width divider
package var_bw_div_pkg;
  localparam int WIDTH = 16;
  localparam int LANE_W = WIDTH / 2;
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/var_bw_div_if.sv
// var_bw_div_if: operand/result handshake bundle for var_bw_div
interface var_bw_div_if #(parameter int W = var_bw_div_pkg::WIDTH);
  logic         in_valid;
  logic         in_ready;
  logic         para_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic [1:0]   dbz;
  modport slave (input in_valid, para_mode, a, b, out_ready,
                 output in_ready, out_valid, q, r, dbz);
  modport master (output in_valid, para_mode, a, b, out_ready,
                  input in_ready, out_valid, q, r, dbz);
endinterface

// File: rtl/var_bw_div_step.sv
// var_bw_div_step: one restoring iteration; quotient bits shift into the dividend register
module var_bw_div_step #(parameter int W = 16) (
  input  logic         para_i,
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dvd_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] dvd_o
);
  localparam int L = W / 2;
  logic [W:0] sh_f;
  logic [L:0] sh_h, sh_l;
  logic       qf, qh, ql;
  always_comb begin
    sh_f = {rem_i, dvd_i[W-1]};
    sh_h = {rem_i[W-1:L], dvd_i[W-1]};
    sh_l = {rem_i[L-1:0], dvd_i[L-1]};
    qf = sh_f >= {1'b0, div_i};
    qh = sh_h >= {1'b0, div_i[W-1:L]};
    ql = sh_l >= {1'b0, div_i[L-1:0]};
    // in lane mode each half keeps its own borrow and shift chain
    rem_o = para_i ? {qh ? L'(sh_h - {1'b0, div_i[W-1:L]}) : sh_h[L-1:0],
                      ql ? L'(sh_l - {1'b0, div_i[L-1:0]}) : sh_l[L-1:0]}
                   : (qf ? W'(sh_f - {1'b0, div_i}) : sh_f[W-1:0]);
    dvd_o = para_i ? {dvd_i[W-2:L], qh, dvd_i[L-2:0], ql} : {dvd_i[W-2:0], qf};
  end
endmodule

// File: rtl/var_bw_div.sv
// var_bw_div: radix-2 restoring divider, one WIDTH-bit or two WIDTH/2-bit lanes
module var_bw_div #(parameter int WIDTH = var_bw_div_pkg::WIDTH) (
  input logic        clk,
  input logic        rst_n,
  var_bw_div_if.slave bus
);
  import var_bw_div_pkg::*;
  localparam int L = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             para_q;
  logic [WIDTH-1:0] dvd_q, div_q, rem_q, q_q, r_q, rem_d, dvd_d;
  logic [1:0]       dbz_q, dbz_d;
  var_bw_div_step #(.W(WIDTH)) u_step (
    .para_i(para_q), .rem_i(rem_q), .dvd_i(dvd_q), .div_i(div_q),
    .rem_o(rem_d), .dvd_o(dvd_d)
  );
  assign dbz_d = para_q ? {div_q[WIDTH-1:L] == '0, div_q[L-1:0] == '0} : {2{div_q == '0}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (bus.in_valid ? BUSY : IDLE)
            : state_q == BUSY ? (cnt_q == CW'(1) ? DONE : BUSY)
            : (bus.out_ready ? IDLE : DONE);
  always_comb begin
    bus.in_ready  = state_q == IDLE;
    bus.out_valid = state_q == DONE;
    bus.q         = q_q;
    bus.r         = r_q;
    bus.dbz       = dbz_q;
  end
  // zero divisors need no special path: every trial subtract succeeds, giving q=ones, r=dividend
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      para_q <= 1'b0;
      dvd_q  <= '0;
      div_q  <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      dbz_q  <= '0;
    end else if (state_q == IDLE && bus.in_valid) begin
      cnt_q  <= bus.para_mode ? CW'(L) : CW'(WIDTH);
      para_q <= bus.para_mode;
      dvd_q  <= bus.a;
      div_q  <= bus.b;
      rem_q  <= '0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - CW'(1);
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      if (cnt_q == CW'(1)) begin
        q_q   <= dvd_d;
        r_q   <= rem_d;
        dbz_q <= dbz_d;
      end
    end
endmodule

// File: tb/tb_var_bw_div.sv
// tb_var_bw_div: directed checks of var_bw_div results, latency, backpressure and reset
module tb_var_bw_div;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  var_bw_div_if #(.W(16)) bus ();
  var_bw_div #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic start_op(input logic pm, input logic [15:0] aa, input logic [15:0] bb);
    @(negedge clk);
    bus.para_mode = pm;
    bus.a = aa;
    bus.b = bb;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = 16'h0;
    bus.b = 16'h0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 40);
  endtask

  task automatic take();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if ({bus.q, bus.r, bus.dbz} !== 34'h0) begin bad++; $display("FAIL reset_outputs got q=%h r=%h dbz=%b want 0", bus.q, bus.r, bus.dbz); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_div(input string nm, input logic pm, input logic [15:0] aa, input logic [15:0] bb,
                          input logic [15:0] eq, input logic [15:0] er, input logic [1:0] ed, input int elat);
    int lat;
    start_op(pm, aa, bb);
    wait_done(lat);
    total++; if (lat !== elat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, elat); end
    total++; if (bus.q !== eq) begin bad++; $display("FAIL %s_q got=%h want=%h", nm, bus.q, eq); end
    total++; if (bus.r !== er) begin bad++; $display("FAIL %s_r got=%h want=%h", nm, bus.r, er); end
    total++; if (bus.dbz !== ed) begin bad++; $display("FAIL %s_dbz got=%b want=%b", nm, bus.dbz, ed); end
    take();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(1'b0, 16'h00FF, 16'h0010);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.out_valid, bus.in_ready, bus.q, bus.r, bus.dbz} !== {1'b1, 1'b0, 16'h000F, 16'h000F, 2'b00}) begin
        bad++;
        $display("FAIL bp_hold%0d got ov=%b ir=%b q=%h r=%h dbz=%b want ov=1 ir=0 q=000f r=000f dbz=00",
                 i, bus.out_valid, bus.in_ready, bus.q, bus.r, bus.dbz);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    total++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin bad++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid); end
    bus.para_mode = 1'b1;
    bus.a = 16'h6407;
    bus.b = 16'h0A02;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept got ir=%b want=0", bus.in_ready); end
    wait_done(lat);
    total++; if (lat !== 8 || bus.q !== 16'h0A03 || bus.r !== 16'h0001) begin bad++; $display("FAIL bp_next got lat=%0d q=%h r=%h want lat=8 q=0a03 r=0001", lat, bus.q, bus.r); end
    take();
  endtask

  task automatic test_reset_mid();
    start_op(1'b0, 16'hABCD, 16'h0003);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_ov got=%b want=0", bus.out_valid); end
    total++; if ({bus.q, bus.r, bus.dbz} !== 34'h0) begin bad++; $display("FAIL mid_rst_outputs got q=%h r=%h dbz=%b want 0", bus.q, bus.r, bus.dbz); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_release got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid); end
    repeat (12) begin
      @(posedge clk);
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_stale got ov=%b want=0", bus.out_valid); end
    end
    test_div("after_rst", 1'b0, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 2'b00, 16);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.para_mode = 1'b0;
    bus.a = 16'h0;
    bus.b = 16'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_div("full",       1'b0, 16'hFFFF, 16'h0003, 16'h5555, 16'h0000, 2'b00, 16);
    test_div("para",       1'b1, 16'h6407, 16'h0A02, 16'h0A03, 16'h0001, 2'b00, 8);
    test_div("para_dbz_lo",1'b1, 16'h1234, 16'h0500, 16'h03FF, 16'h0334, 2'b01, 8);
    test_div("para_dbz_hi",1'b1, 16'h3409, 16'h0004, 16'hFF02, 16'h3401, 2'b10, 8);
    test_div("full_dbz",   1'b0, 16'hABCD, 16'h0000, 16'hFFFF, 16'hABCD, 2'b11, 16);
    test_div("full_nosplit",1'b0,16'h1234, 16'h0100, 16'h0012, 16'h0034, 2'b00, 16);
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
